pipe_hazard_scoreboard: RTL and testbench

- Parametrised hazard, stall and bypass controller for the 5-stage pipe (F, D, X, M, W).
- Adds a per-register scoreboard for out-of-order multicycle (mul/div) writebacks with bounded outstanding depth. Also covers load-use stall, branch flush, MX/WX operand-select generation and a saturating stall counter.
- Sits beside the pipe latches; drives PC/FD hold, DX bubble, FD flush and the X-stage ALU operand muxes.

---
 rtl/pipe_hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, stall and bypass control for the F/D/X/M/W pipe, with a per-register
// scoreboard that tracks out-of-order multicycle (mul/div) writebacks.
module pipe_hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int RW       = 5,
  parameter int MD_DEPTH = 4,
  parameter int STALL_W  = 16
) (
  input  logic               clock,
  input  logic               clrn,
  input  logic               d_valid,
  input  logic [RW-1:0]      d_rs,
  input  logic [RW-1:0]      d_rt,
  input  logic [RW-1:0]      d_rd,
  input  logic [2:0]         d_use,
  input  logic               d_writes,
  input  logic               d_is_md,
  input  logic [RW-1:0]      x_rs,
  input  logic [RW-1:0]      x_rt,
  input  logic [RW-1:0]      x_rd,
  input  logic               x_writes,
  input  logic               x_is_load,
  input  logic [RW-1:0]      m_rd,
  input  logic [RW-1:0]      w_rd,
  input  logic               m_writes,
  input  logic               w_writes,
  input  logic               branch_taken,
  input  logic               md_wb_valid,
  input  logic [RW-1:0]      md_wb_rd,
  output logic               stall_fd,
  output logic               bubble_dx,
  output logic               flush_fd,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [NREGS-1:0]   sb_busy,
  output logic [3:0]         md_count,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               sb_err
);

  localparam int         EXT    = 2 ** RW;
  localparam logic [3:0] MD_MAX = 4'(MD_DEPTH);

  // Qualification: x/m/w_writes are already valid-qualified upstream; d_* fields
  // matter only while d_valid=1; md_wb_valid is a one-cycle pulse per writeback
  // with no backpressure (the unit never waits on this block).

  logic [EXT-1:0] busy_ext;
  logic [EXT-1:0] busy_nxt;
  logic           load_use;
  logic           sb_haz;
  logic           struct_haz;
  logic           stall;
  logic           issue;
  logic           wb_dec;
  logic           wb_err;

  function automatic logic hit(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Widened view so any RW-bit index is in range; bit 0 is never set.
  always_comb begin
    busy_ext = '0;
    busy_ext[NREGS-1:0] = sb_busy;
  end

  always_comb begin
    load_use = d_valid & x_is_load & x_writes &
               ((d_use[0] & hit(x_rd, d_rs)) |
                (d_use[1] & hit(x_rd, d_rt)) |
                (d_use[2] & hit(x_rd, d_rd)));
    sb_haz = d_valid & ((d_use[0] & busy_ext[d_rs]) |
                        (d_use[1] & busy_ext[d_rt]) |
                        (d_use[2] & busy_ext[d_rd]) |
                        (d_writes & busy_ext[d_rd]));
    struct_haz = d_valid & d_is_md & (md_count == MD_MAX);
    stall      = (load_use | sb_haz | struct_haz) & ~branch_taken;
    issue      = d_valid & d_is_md & ~stall & ~branch_taken;
    wb_dec     = md_wb_valid & (md_count != 4'd0);
    wb_err     = md_wb_valid & (~busy_ext[md_wb_rd] | (md_count == 4'd0));
  end

  assign stall_fd  = stall;
  assign bubble_dx = stall | branch_taken;
  assign flush_fd  = branch_taken;

  // M is newer than W, so it wins when both hold the same register.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (m_writes && hit(m_rd, x_rs))      fwd_a = 2'b01;
    else if (w_writes && hit(w_rd, x_rs)) fwd_a = 2'b10;
    if (m_writes && hit(m_rd, x_rt))      fwd_b = 2'b01;
    else if (w_writes && hit(w_rd, x_rt)) fwd_b = 2'b10;
  end

  // Clear first, then set: a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy_ext;
    if (md_wb_valid)              busy_nxt[md_wb_rd] = 1'b0;
    if (issue && (d_rd != '0))    busy_nxt[d_rd]     = 1'b1;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      sb_busy   <= '0;
      md_count  <= 4'd0;
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      sb_busy <= busy_nxt[NREGS-1:0];
      case ({issue, wb_dec})
        2'b10:   md_count <= md_count + 4'd1;
        2'b01:   md_count <= md_count - 4'd1;
        default: md_count <= md_count;
      endcase
      if (wb_err) sb_err <= 1'b1;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: a table of combinational vectors
// against the cleared state, then hand-written multi-cycle scoreboard sequences.
module tb_pipe_hazard_scoreboard;

  localparam int NREGS   = 32;
  localparam int RW      = 5;
  localparam int STALL_W = 16;

  logic               clock = 1'b0;
  logic               clrn;
  logic               d_valid, d_writes, d_is_md;
  logic [RW-1:0]      d_rs, d_rt, d_rd;
  logic [2:0]         d_use;
  logic [RW-1:0]      x_rs, x_rt, x_rd, m_rd, w_rd, md_wb_rd;
  logic               x_writes, x_is_load, m_writes, w_writes;
  logic               branch_taken, md_wb_valid;
  logic               stall_fd, bubble_dx, flush_fd, sb_err;
  logic [1:0]         fwd_a, fwd_b;
  logic [NREGS-1:0]   sb_busy;
  logic [3:0]         md_count;
  logic [STALL_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];

  pipe_hazard_scoreboard #(.NREGS(NREGS), .RW(RW), .MD_DEPTH(4), .STALL_W(STALL_W)) dut (
    .clock(clock), .clrn(clrn),
    .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_use(d_use),
    .d_writes(d_writes), .d_is_md(d_is_md),
    .x_rs(x_rs), .x_rt(x_rt), .x_rd(x_rd), .x_writes(x_writes), .x_is_load(x_is_load),
    .m_rd(m_rd), .w_rd(w_rd), .m_writes(m_writes), .w_writes(w_writes),
    .branch_taken(branch_taken), .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .sb_busy(sb_busy), .md_count(md_count),
    .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]    tag;
    logic          dv;
    logic [RW-1:0] rs, rt, rd;
    logic [2:0]    use_b;
    logic          dw, dmd;
    logic [RW-1:0] xrs, xrt, xrd;
    logic          xw, xld;
    logic [RW-1:0] mrd;
    logic          mw;
    logic [RW-1:0] wrd;
    logic          ww, br;
    logic          e_stall, e_bub, e_flush;
    logic [1:0]    e_fa, e_fb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_rs = 0; d_rt = 0; d_rd = 0; d_use = 0; d_writes = 0; d_is_md = 0;
    x_rs = 0; x_rt = 0; x_rd = 0; x_writes = 0; x_is_load = 0;
    m_rd = 0; m_writes = 0; w_rd = 0; w_writes = 0;
    branch_taken = 0; md_wb_valid = 0; md_wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    clrn = 0;
    #7;
    clrn = 1;
    tick();
  endtask

  task automatic set_d(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input logic [2:0] u, input logic w, input logic md);
    d_valid = 1; d_rs = rs; d_rt = rt; d_rd = rd; d_use = u; d_writes = w; d_is_md = md;
  endtask

  initial begin
    //             tag dv rs rt rd use dw md xrs xrt xrd xw xld mrd mw wrd ww br  st bu fl fa fb
    vecs[0]  = '{8'd0, 1, 5, 1, 6, 3'b011, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{8'd1, 0, 5, 1, 6, 3'b011, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{8'd2, 1, 0, 1, 6, 3'b001, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{8'd3, 1, 2, 3, 5, 3'b100, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[4]  = '{8'd4, 1, 5, 5, 6, 3'b000, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{8'd5, 1, 5, 1, 6, 3'b011, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{8'd6, 1, 5, 1, 6, 3'b011, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{8'd7, 1, 5, 1, 6, 3'b011, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    vecs[8]  = '{8'd8, 0, 0, 0, 0, 3'b000, 0, 0, 3, 3, 0, 0, 0, 3, 1, 3, 1, 0, 0, 0, 0, 1, 1};
    vecs[9]  = '{8'd9, 0, 0, 0, 0, 3'b000, 0, 0, 3, 3, 0, 0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 2, 2};
    vecs[10] = '{8'd10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{8'd11, 0, 0, 0, 0, 3'b000, 0, 0, 4, 9, 0, 0, 0, 9, 1, 4, 1, 0, 0, 0, 0, 2, 1};
    vecs[12] = '{8'd12, 0, 0, 0, 0, 3'b000, 0, 0, 3, 3, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{8'd13, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{8'd14, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};

    do_reset();
    chk("rst_sb_busy", 64'(sb_busy), 64'd0);
    chk("rst_md_count", 64'(md_count), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);

    // Table vectors: purely combinational against the cleared scoreboard.
    for (int i = 0; i < 15; i++) begin
      d_valid = vecs[i].dv; d_rs = vecs[i].rs; d_rt = vecs[i].rt; d_rd = vecs[i].rd;
      d_use = vecs[i].use_b; d_writes = vecs[i].dw; d_is_md = vecs[i].dmd;
      x_rs = vecs[i].xrs; x_rt = vecs[i].xrt; x_rd = vecs[i].xrd;
      x_writes = vecs[i].xw; x_is_load = vecs[i].xld;
      m_rd = vecs[i].mrd; m_writes = vecs[i].mw; w_rd = vecs[i].wrd; w_writes = vecs[i].ww;
      branch_taken = vecs[i].br;
      exp_q.push_back({vecs[i].e_stall, vecs[i].e_bub, vecs[i].e_flush, vecs[i].e_fa, vecs[i].e_fb});
      #2;
      chk($sformatf("vec%0d", vecs[i].tag), 64'({stall_fd, bubble_dx, flush_fd, fwd_a, fwd_b}),
          64'(exp_q.pop_front()));
      #3;
    end

    // Load-use: one stall cycle, then lw in M forwards to X.
    do_reset();
    set_d(5, 1, 6, 3'b011, 1, 0);
    x_rd = 5; x_writes = 1; x_is_load = 1;
    #1;
    chk("lu_stall", 64'({stall_fd, bubble_dx}), 64'b11);
    tick();
    x_rs = 5; x_rt = 1; x_rd = 6; x_is_load = 0; m_rd = 5; m_writes = 1;
    #1;
    chk("lu_release", 64'(stall_fd), 64'd0);
    chk("lu_fwd_a", 64'(fwd_a), 64'd1);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);

    // Multicycle RAW: stall held through the writeback cycle, released after.
    do_reset();
    set_d(1, 2, 7, 3'b011, 1, 1);
    #1;
    chk("mul_issue_nostall", 64'(stall_fd), 64'd0);
    tick();
    chk("mul_busy7", 64'(sb_busy[7]), 64'd1);
    chk("mul_count1", 64'(md_count), 64'd1);
    set_d(7, 2, 8, 3'b011, 1, 0);
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk($sformatf("raw_stall_c%0d", c), 64'(stall_fd), 64'd1);
      tick();
    end
    md_wb_valid = 1; md_wb_rd = 7;
    #1;
    chk("raw_stall_wb_cycle", 64'(stall_fd), 64'd1);
    tick();
    md_wb_valid = 0;
    #1;
    chk("raw_release", 64'(stall_fd), 64'd0);
    chk("raw_busy7_clear", 64'(sb_busy[7]), 64'd0);
    chk("raw_count0", 64'(md_count), 64'd0);
    chk("raw_stall_cnt", 64'(stall_cnt), 64'd16);
    chk("raw_no_err", 64'(sb_err), 64'd0);

    // Structural: four outstanding, fifth waits for a writeback.
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      set_d(0, 0, 5'(r), 3'b000, 1, 1);
      tick();
    end
    chk("st_count4", 64'(md_count), 64'd4);
    chk("st_busy", 64'(sb_busy), 64'h1E);
    set_d(0, 0, 9, 3'b000, 1, 1);
    #1;
    chk("st_stall", 64'(stall_fd), 64'd1);
    tick();
    md_wb_valid = 1; md_wb_rd = 1;
    #1;
    chk("st_stall_wb_cycle", 64'(stall_fd), 64'd1);
    tick();
    md_wb_valid = 0;
    chk("st_count3", 64'(md_count), 64'd3);
    #1;
    chk("st_release", 64'(stall_fd), 64'd0);
    tick();
    chk("st_count4_again", 64'(md_count), 64'd4);
    chk("st_busy_after", 64'(sb_busy), 64'h21C);

    // Branch squashes a load-use stall and a would-be md issue.
    do_reset();
    set_d(5, 1, 6, 3'b011, 1, 1);
    x_rd = 5; x_writes = 1; x_is_load = 1; branch_taken = 1;
    #1;
    chk("br_outs", 64'({stall_fd, bubble_dx, flush_fd}), 64'b011);
    tick();
    chk("br_no_issue", 64'({sb_busy, md_count}), 64'd0);
    chk("br_stall_cnt", 64'(stall_cnt), 64'd0);

    // WAW against a pending multicycle destination.
    do_reset();
    set_d(0, 0, 7, 3'b000, 1, 1);
    tick();
    set_d(1, 0, 7, 3'b001, 1, 0);
    #1;
    chk("waw_stall", 64'(stall_fd), 64'd1);
    d_writes = 0;
    #1;
    chk("waw_nowrite_nostall", 64'(stall_fd), 64'd0);

    // Spurious writeback, sticky error, same-cycle issue+wb, async reset mid-stall.
    do_reset();
    md_wb_valid = 1; md_wb_rd = 12;
    tick();
    md_wb_valid = 0;
    chk("err_set", 64'(sb_err), 64'd1);
    chk("err_no_underflow", 64'(md_count), 64'd0);
    tick();
    chk("err_sticky", 64'(sb_err), 64'd1);
    set_d(0, 0, 4, 3'b000, 1, 1);
    tick();
    chk("iw_pre_count", 64'(md_count), 64'd1);
    set_d(0, 0, 4, 3'b000, 0, 1);
    md_wb_valid = 1; md_wb_rd = 4;
    tick();
    md_wb_valid = 0;
    chk("iw_busy4", 64'(sb_busy[4]), 64'd1);
    chk("iw_count", 64'(md_count), 64'd1);
    set_d(4, 0, 6, 3'b001, 1, 0);
    tick();
    chk("rs_stalling", 64'(stall_cnt), 64'd1);
    #2;
    clrn = 0;
    #1;
    chk("arst_state", 64'({sb_busy, md_count, stall_cnt, sb_err}), 64'd0);
    chk("arst_stall", 64'(stall_fd), 64'd0);
    clrn = 1;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
